// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the 5-stage MIPS pipeline:
//   - bit positions of the control field carried through the pipeline
//     registers (ID/EX, EX/MEM, MEM/WB),
//   - MEM-stage sequencer state encoding.
// -----------------------------------------------------------------------------
package mips_pkg;

   // Control field layout, identical in every pipeline register.
   localparam int CTL_REGWRITE = 0;
   localparam int CTL_MEMTOREG = 1;
   localparam int CTL_MEMREAD  = 2;
   localparam int CTL_MEMWRITE = 3;
   localparam int CTL_W        = 4;

   // MEM-stage sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage : mips_pkg

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage sequencer. Converts the memory control bits, address and store
// data leaving EX/MEM into a req/ready transaction on a multi-cycle data
// memory, stalls the pipeline while the access is outstanding, returns load
// data with a one-cycle strobe, and reports misaligned accesses and timeouts.
//
// Ports
//   clk, rst_n      pipeline clock (rising edge), async active-low reset
//   control_in      EX/MEM control field (RegWrite, MemtoReg, MemRead, MemWrite)
//   alu_result_in   effective address
//   rd2_in          store data
//   mem_req         request to data memory (high for the whole ACCESS phase)
//   mem_we          1 = write, 0 = read; valid while mem_req is high
//   mem_addr        word address; valid while mem_req is high
//   mem_wdata       store data; valid while mem_req is high
//   mem_ready       memory completion, sampled only in ACCESS
//   mem_rdata       read data, valid with mem_ready
//   stall           combinational: hold the front of the pipeline
//   load_data       last captured read data
//   load_valid      one-cycle pulse in DONE for a completed read
//   align_err       one-cycle pulse after a misaligned access was rejected
//   bus_err         one-cycle pulse in DONE for an access aborted on timeout
//   dbg_state       current sequencer state (mips_pkg::state_t encoding)
//
// Handshake: mem_req rises on entry to ACCESS and stays high, with address,
// data and direction frozen, until the first ACCESS cycle in which mem_ready
// is high (the transfer completes in that cycle) or the timeout limit is
// reached (the request is withdrawn without completion). mem_ready seen in
// any other state is ignored.
// -----------------------------------------------------------------------------
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CTL_W-1:0]   control_in,
   input  logic [31:0]        alu_result_in,
   input  logic [31:0]        rd2_in,
   output logic               mem_req,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ready,
   input  logic [31:0]        mem_rdata,
   output logic               stall,
   output logic [31:0]        load_data,
   output logic               load_valid,
   output logic               align_err,
   output logic               bus_err,
   output logic [1:0]         dbg_state
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   // ---------------------------------------------------------------------------
   // Decode of the EX/MEM control field
   // ---------------------------------------------------------------------------
   logic mem_op;
   logic is_write;
   logic aligned;
   logic ctl_unused;

   assign mem_op     = control_in[CTL_MEMREAD] | control_in[CTL_MEMWRITE];
   // MemRead and MemWrite both set is resolved as a write.
   assign is_write   = control_in[CTL_MEMWRITE];
   assign aligned    = (alu_result_in[1:0] == 2'b00);
   // Register-file controls travel through this stage untouched.
   assign ctl_unused = control_in[CTL_REGWRITE] ^ control_in[CTL_MEMTOREG];

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_t      state_q,      state_d;
   logic [7:0]  cnt_q,        cnt_d;
   logic        req_q,        req_d;
   logic        we_q,         we_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic [31:0] load_data_q,  load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        align_err_q,  align_err_d;
   logic        bus_err_q,    bus_err_d;
   logic        stall_c;
   logic [7:0]  cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         load_data_q  <= 32'd0;
         load_valid_q <= 1'b0;
         align_err_q  <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         align_err_q  <= align_err_d;
         bus_err_q    <= bus_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      align_err_d  = 1'b0;
      bus_err_d    = 1'b0;
      stall_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (aligned) begin
                  // Stall already in this cycle so EX/MEM keeps the
                  // instruction while the request is launched.
                  stall_c = 1'b1;
                  state_d = ACCESS;
                  req_d   = 1'b1;
                  we_d    = is_write;
                  addr_d  = alu_result_in;
                  wdata_d = rd2_in;
                  cnt_d   = 8'd0;
               end else begin
                  align_err_d = 1'b1;
               end
            end
         end

         ACCESS: begin
            stall_c = 1'b1;
            if (mem_ready) begin
               // Completion takes priority over a timeout hit in the same cycle.
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  load_data_d  = mem_rdata;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_inc == TMO_LIMIT) begin
               state_d   = DONE;
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               cnt_d     = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         DONE: begin
            // The mem_op still visible here is the instruction just served;
            // the pipeline moves past it at the end of this cycle.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Gated with rst_n so an asserted reset releases the pipeline at once,
   // even if EX/MEM still presents a memory instruction.
   assign stall      = stall_c & rst_n;
   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign align_err  = align_err_q;
   assign bus_err    = bus_err_q;
   assign dbg_state  = state_q;

   // ---------------------------------------------------------------------------
   // Invariants
   // ---------------------------------------------------------------------------
   a_req_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
      req_q == (state_q == ACCESS));

   a_done_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(load_valid_q && bus_err_q));

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// The reference is a transaction-level planner: each instruction is laid out
// on a cycle timeline (one cycle for a non-memory or misaligned instruction;
// launch, n access cycles and a completion cycle for an aligned access) and
// the expected waveform of every output is written into per-cycle arrays. A
// driver replays the stimulus and one compare process checks all outputs on
// every cycle. Directed instructions at the head of the plan get additional
// literal checks on the observed waveform.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
   import mips_pkg::*;

   localparam int TMO  = 16;
   localparam int MAXC = 4096;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  control_in;
   logic [31:0] alu_result_in;
   logic [31:0] rd2_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        align_err;
   logic        bus_err;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .control_in    (control_in),
      .alu_result_in (alu_result_in),
      .rd2_in        (rd2_in),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata),
      .stall         (stall),
      .load_data     (load_data),
      .load_valid    (load_valid),
      .align_err     (align_err),
      .bus_err       (bus_err),
      .dbg_state     (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Plan: stimulus and expected outputs per cycle
   // ---------------------------------------------------------------------------
   logic [3:0]  stim_ctl  [MAXC];
   logic [31:0] stim_addr [MAXC];
   logic [31:0] stim_wd   [MAXC];
   logic        stim_rdy  [MAXC];
   logic [31:0] stim_rd   [MAXC];

   logic        e_stall [MAXC];
   logic        e_req   [MAXC];
   logic        e_we    [MAXC];
   logic [31:0] e_addr  [MAXC];
   logic [31:0] e_wd    [MAXC];
   logic        e_lv    [MAXC];
   logic        e_ae    [MAXC];
   logic        e_be    [MAXC];
   logic [31:0] e_ld    [MAXC];
   logic        ld_set  [MAXC];
   logic [31:0] ld_val  [MAXC];

   // Observed waveform, for the literal checks on directed instructions.
   logic        o_stall [MAXC];
   logic        o_req   [MAXC];
   logic        o_we    [MAXC];
   logic        o_lv    [MAXC];
   logic        o_ae    [MAXC];
   logic        o_be    [MAXC];
   logic [31:0] o_ld    [MAXC];

   int ncyc;
   int cur_cyc;
   bit chk_en;
   int n_checks;
   int n_fail;

   task automatic chk(input string name, input int c, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, c, act, exp);
      end
   endtask

   task automatic init_plan();
      for (int i = 0; i < MAXC; i++) begin
         stim_ctl[i] = '0; stim_addr[i] = '0; stim_wd[i] = '0;
         stim_rdy[i] = 1'b0; stim_rd[i] = '0;
         e_stall[i] = 1'b0; e_req[i] = 1'b0; e_we[i] = 1'b0;
         e_addr[i] = '0; e_wd[i] = '0; e_lv[i] = 1'b0; e_ae[i] = 1'b0;
         e_be[i] = 1'b0; e_ld[i] = '0; ld_set[i] = 1'b0; ld_val[i] = '0;
         o_stall[i] = 1'b0; o_req[i] = 1'b0; o_we[i] = 1'b0; o_lv[i] = 1'b0;
         o_ae[i] = 1'b0; o_be[i] = 1'b0; o_ld[i] = '0;
      end
      ncyc = 0;
   endtask

   // Instruction visible on EX/MEM for one cycle; ready/rdata outside an
   // access are noise that must be ignored.
   task automatic put_cycle(input int c, input logic [3:0] ctl,
                            input logic [31:0] addr, input logic [31:0] wd);
      stim_ctl[c]  = ctl;
      stim_addr[c] = addr;
      stim_wd[c]   = wd;
      stim_rdy[c]  = 1'($urandom_range(0, 1));
      stim_rd[c]   = $urandom;
   endtask

   // dly = number of access cycles without ready before ready arrives;
   // dly >= TMO means ready never arrives in time.
   task automatic add_instr(input logic [3:0] ctl, input logic [31:0] addr,
                            input logic [31:0] wd, input int dly,
                            input logic [31:0] rd);
      int  t;
      int  n;
      bit  is_mem;
      bit  wr;
      bit  tmo;
      t      = ncyc;
      is_mem = ctl[2] | ctl[3];
      wr     = ctl[3];
      if (!is_mem || addr[1:0] != 2'b00) begin
         put_cycle(t, ctl, addr, wd);
         if (is_mem) e_ae[t+1] = 1'b1;
         ncyc = t + 1;
      end else begin
         tmo = (dly >= TMO);
         n   = tmo ? TMO : dly + 1;
         // Launch cycle t, access cycles t+1..t+n, completion cycle t+n+1.
         for (int k = 0; k <= n + 1; k++) put_cycle(t + k, ctl, addr, wd);
         for (int k = 0; k <= n; k++) e_stall[t+k] = 1'b1;
         for (int k = 1; k <= n; k++) begin
            e_req[t+k]    = 1'b1;
            e_we[t+k]     = wr;
            e_addr[t+k]   = addr;
            e_wd[t+k]     = wd;
            stim_rdy[t+k] = 1'b0;
         end
         if (!tmo) begin
            stim_rdy[t+n] = 1'b1;
            stim_rd[t+n]  = rd;
            if (!wr) begin
               e_lv[t+n+1]   = 1'b1;
               ld_set[t+n+1] = 1'b1;
               ld_val[t+n+1] = rd;
            end
         end else begin
            e_be[t+n+1] = 1'b1;
         end
         ncyc = t + n + 2;
      end
   endtask

   task automatic finish_plan();
      logic [31:0] cur;
      for (int i = 0; i < 3; i++) add_instr(4'b0001, 32'h0, 32'h0, 0, 32'h0);
      cur = '0;
      for (int c = 0; c < ncyc; c++) begin
         if (ld_set[c]) cur = ld_val[c];
         e_ld[c] = cur;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic run_plan();
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         control_in    = stim_ctl[c];
         alu_result_in = stim_addr[c];
         rd2_in        = stim_wd[c];
         mem_ready     = stim_rdy[c];
         mem_rdata     = stim_rd[c];
         cur_cyc       = c;
         chk_en        = 1'b1;
      end
      @(posedge clk); #1;
      chk_en     = 1'b0;
      control_in = '0;
      mem_ready  = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard: every output, every cycle of the plan
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (chk_en) begin
         o_stall[cur_cyc] = stall;
         o_req[cur_cyc]   = mem_req;
         o_we[cur_cyc]    = mem_we;
         o_lv[cur_cyc]    = load_valid;
         o_ae[cur_cyc]    = align_err;
         o_be[cur_cyc]    = bus_err;
         o_ld[cur_cyc]    = load_data;
         chk("stall", cur_cyc, 32'(stall), 32'(e_stall[cur_cyc]));
         chk("mem_req", cur_cyc, 32'(mem_req), 32'(e_req[cur_cyc]));
         if (e_req[cur_cyc]) begin
            chk("mem_we", cur_cyc, 32'(mem_we), 32'(e_we[cur_cyc]));
            chk("mem_addr", cur_cyc, mem_addr, e_addr[cur_cyc]);
            chk("mem_wdata", cur_cyc, mem_wdata, e_wd[cur_cyc]);
         end
         chk("load_valid", cur_cyc, 32'(load_valid), 32'(e_lv[cur_cyc]));
         chk("align_err", cur_cyc, 32'(align_err), 32'(e_ae[cur_cyc]));
         chk("bus_err", cur_cyc, 32'(bus_err), 32'(e_be[cur_cyc]));
         chk("load_data", cur_cyc, load_data, e_ld[cur_cyc]);
      end
   end

   function automatic int count_o(input int sel, input int from, input int to);
      int s;
      s = 0;
      for (int c = from; c < to; c++) begin
         case (sel)
            0:       s += int'(o_stall[c]);
            1:       s += int'(o_req[c]);
            2:       s += int'(o_lv[c]);
            3:       s += int'(o_be[c]);
            default: s += int'(o_ae[c]);
         endcase
      end
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   int          t1, t2, t3, t4, t5, t6, t7;
   logic [3:0]  r_ctl;
   logic [31:0] r_addr;
   int          r_kind;
   int          r_dly;

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      chk_en        = 1'b0;
      cur_cyc       = 0;
      rst_n         = 1'b0;
      control_in    = '0;
      alu_result_in = '0;
      rd2_in        = '0;
      mem_ready     = 1'b0;
      mem_rdata     = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 0, 32'(mem_req), 32'd0);
      chk("rst_stall", 0, 32'(stall), 32'd0);
      chk("rst_load_valid", 0, 32'(load_valid), 32'd0);
      chk("rst_align_err", 0, 32'(align_err), 32'd0);
      chk("rst_bus_err", 0, 32'(bus_err), 32'd0);
      chk("rst_load_data", 0, load_data, 32'd0);
      chk("rst_mem_addr", 0, mem_addr, 32'd0);
      chk("rst_state", 0, 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // Directed instructions followed by random traffic
      init_plan();
      t1 = ncyc; add_instr(4'b0111, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
      t2 = ncyc; add_instr(4'b1000, 32'h0000_0020, 32'h1234_5678, 4, 32'h0);
      t3 = ncyc; add_instr(4'b0100, 32'h0000_0013, 32'h0, 0, 32'h0);
      t4 = ncyc; add_instr(4'b0100, 32'h0000_0030, 32'h0, 99, 32'h0);
      t5 = ncyc; add_instr(4'b0100, 32'h0000_0034, 32'h0, TMO - 1, 32'h5A5A_0001);
      t6 = ncyc; add_instr(4'b0101, 32'h0000_0040, 32'h0, 0, 32'h1111_2222);
      add_instr(4'b0101, 32'h0000_0044, 32'h0, 0, 32'h3333_4444);
      add_instr(4'b1100, 32'h0000_0048, 32'hABCD_0000, 2, 32'h0);

      for (int i = 0; i < 160 && ncyc < MAXC - 48; i++) begin
         r_kind = $urandom_range(0, 9);
         r_ctl  = 4'($urandom_range(0, 3));
         if (r_kind >= 3 && r_kind <= 5) r_ctl[2] = 1'b1;
         else if (r_kind >= 6 && r_kind <= 8) r_ctl[3] = 1'b1;
         else if (r_kind == 9) r_ctl[3:2] = 2'b11;
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
         case ($urandom_range(0, 9))
            0:       r_dly = TMO + $urandom_range(0, 3);
            1:       r_dly = TMO - 1;
            default: r_dly = $urandom_range(0, 6);
         endcase
         add_instr(r_ctl, r_addr, $urandom, r_dly, $urandom);
      end
      finish_plan();

      // Literal expectations pinning the planner on the directed cases
      chk("plan_load_stall_cycles", t1, 32'(e_stall[t1] + e_stall[t1+1] + e_stall[t1+2]), 32'd2);
      chk("plan_load_data", t1 + 2, e_ld[t1+2], 32'hDEAD_BEEF);
      chk("plan_timeout_be_cycle", t4 + 17, 32'(e_be[t4+17]), 32'd1);

      run_plan();

      // Literal checks on the observed waveform
      chk("load_stall_cycles", t1, 32'(count_o(0, t1, t1 + 3)), 32'd2);
      chk("load_lv_pulses", t1, 32'(count_o(2, t1, t1 + 3)), 32'd1);
      chk("load_data_deadbeef", t1 + 2, o_ld[t1+2], 32'hDEAD_BEEF);
      chk("load_we_low", t1 + 1, 32'(o_we[t1+1]), 32'd0);
      chk("store_req_cycles", t2, 32'(count_o(1, t2, t2 + 7)), 32'd5);
      chk("store_stall_cycles", t2, 32'(count_o(0, t2, t2 + 7)), 32'd6);
      chk("store_no_lv", t2, 32'(count_o(2, t2, t2 + 7)), 32'd0);
      chk("store_we_high", t2 + 3, 32'(o_we[t2+3]), 32'd1);
      chk("misaligned_ae", t3 + 1, 32'(o_ae[t3+1]), 32'd1);
      chk("misaligned_no_stall", t3, 32'(o_stall[t3]), 32'd0);
      chk("misaligned_no_req", t3 + 1, 32'(o_req[t3+1]), 32'd0);
      chk("timeout_be", t4 + 17, 32'(o_be[t4+17]), 32'd1);
      chk("timeout_req_cycles", t4, 32'(count_o(1, t4, t4 + 18)), 32'd16);
      chk("timeout_no_lv", t4, 32'(count_o(2, t4, t4 + 18)), 32'd0);
      chk("ready_at_limit_no_be", t5, 32'(count_o(3, t5, t5 + 18)), 32'd0);
      chk("ready_at_limit_lv", t5 + 17, 32'(o_lv[t5+17]), 32'd1);
      chk("b2b_req_cycles", t6, 32'(count_o(1, t6, t6 + 6)), 32'd2);
      chk("b2b_lv_pulses", t6, 32'(count_o(2, t6, t6 + 6)), 32'd2);
      chk("b2b_no_req_in_done", t6 + 2, 32'(o_req[t6+2]), 32'd0);

      // Reset in the middle of an access
      @(posedge clk); #1;
      control_in    = 4'b0100;
      alu_result_in = 32'h0000_0050;
      rd2_in        = 32'h0;
      mem_ready     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_req", 0, 32'(mem_req), 32'd1);
      chk("pre_reset_stall", 0, 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_req", 0, 32'(mem_req), 32'd0);
      chk("mid_reset_stall", 0, 32'(stall), 32'd0);
      chk("mid_reset_state", 0, 32'(dbg_state), 32'(IDLE));
      chk("mid_reset_load_data", 0, load_data, 32'd0);
      control_in = '0;
      @(negedge clk);
      rst_n = 1'b1;

      init_plan();
      t7 = ncyc; add_instr(4'b0111, 32'h0000_0060, 32'h0, 1, 32'hCAFE_F00D);
      finish_plan();
      run_plan();
      chk("post_reset_lv", t7 + 3, 32'(o_lv[t7+3]), 32'd1);
      chk("post_reset_load_data", t7 + 3, o_ld[t7+3], 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_stage_ctrl

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the 5-stage MIPS pipeline. It turns the memory control bits and address/data leaving the EX/MEM register into a req/ready handshake with a multi-cycle data memory. While an access is outstanding it stalls the pipeline. It returns load data with a one-cycle valid strobe and flags misaligned addresses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 16: ACCESS cycles without `mem_ready` before the access is aborted; legal range 1..255.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- control_in  in  4  EX/MEM control field: bit0 RegWrite, bit1 MemtoReg, bit2 MemRead, bit3 MemWrite.
- alu_result_in  in  32  effective address.
- rd2_in  in  32  store data.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- mem_addr  out  32  word address; valid while `mem_req` is high.
- mem_wdata  out  32  store data; valid while `mem_req` is high.
- mem_ready  in  1  memory completion; sampled only in ACCESS.
- mem_rdata  in  32  read data; valid with `mem_ready`.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- load_data  out  32  captured read data.
- load_valid  out  1  one-cycle pulse: `load_data` is valid for the instruction now leaving MEM.
- align_err  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: access aborted on timeout.

## Operation
- mem_op = MemRead | MemWrite. If both bits are set, the access is treated as a write.
- aligned = (alu_result_in[1:0] == 2'b00).
- State machine:
  - IDLE
    - mem_op & aligned: latch address, data and we; assert `stall` combinationally this cycle; go to ACCESS.
    - mem_op & !aligned: pulse `align_err`; no request, no stall; stay in IDLE.
  - ACCESS
    - `mem_req`=1 and `stall`=1; `mem_addr`, `mem_we`, `mem_wdata` are driven from the latches and stay stable.
    - mem_ready: capture `mem_rdata` if a read; go to DONE.
    - Timeout counter reaches TIMEOUT_CYCLES: go to DONE and set the pending-bus_err flag.
  - DONE
    - `stall`=0, so the pipeline advances at the end of this cycle.
    - `load_valid`=1 for a completed read; `bus_err`=1 if the timeout flag is set.
    - A mem_op presented this cycle is ignored, because it belongs to the same instruction.
    - Always goes to IDLE.
- Timeout counter: 8 bits, cleared on entry to ACCESS, increments each ACCESS cycle without `mem_ready`. If `mem_ready` arrives on the same cycle the limit is reached, `mem_ready` wins and no `bus_err` is raised.
- On a timed-out read, `load_valid`=0 and `load_data` is unchanged.
- `mem_ready` outside ACCESS is ignored.
- `load_data` holds its last captured value until the next completed read.

## Timing
- Reset values, asynchronous: state IDLE; `mem_req`, `mem_we`, `load_valid`, `align_err`, `bus_err` = 0; `mem_addr`, `mem_wdata`, `load_data` = 0; counter = 0.
- `stall` is combinational from state and inputs. Every other output is registered.
- Best-case latency with `mem_ready` on the first ACCESS cycle:
  - T: IDLE, stall.
  - T+1: ACCESS, req, ready.
  - T+2: DONE, load_valid.
  - That is 2 stall cycles per memory instruction.
- Back-to-back memory instructions: the second is seen in the IDLE cycle after DONE, so the minimum spacing is 3 cycles per access.
- Reset during ACCESS drops `mem_req` immediately with no completion. Memory must tolerate an abandoned request.
- Non-memory instructions never stall.

## Structure
- Shared package `mips_pkg`:
  - Control bit index constants CTL_REGWRITE=0, CTL_MEMTOREG=1, CTL_MEMREAD=2, CTL_MEMWRITE=3.
  - State enum {IDLE, ACCESS, DONE}, 2 bits.
- The pipeline registers use the same control constants.
- Single module; no sub-module. The timeout counter stays inline.

## Test plan
- Aligned load, `mem_ready` on the first ACCESS cycle, addr 0x0000_0010, rdata 0xDEAD_BEEF: `stall` high for 2 cycles, `load_valid` pulses once with `load_data`=0xDEAD_BEEF, `mem_we`=0.
- Store to 0x0000_0020 with data 0x1234_5678, `mem_ready` after 4 wait cycles: `mem_req` held 5 cycles with stable addr/data and `mem_we`=1, `stall` high for 6 cycles, no `load_valid`.
- Load from 0x0000_0013: `align_err` pulses 1 cycle; `mem_req` and `stall` never assert.
- TIMEOUT_CYCLES=16 with `mem_ready` tied low: `bus_err` pulses in DONE after 16 ACCESS cycles, `mem_req` drops, `load_valid`=0. Repeat with `mem_ready` on cycle 16: no `bus_err`.
- Two consecutive loads: 2 accesses, 2 `load_valid` pulses, no duplicate request for the first instruction during DONE.
- Assert `rst_n` low mid-ACCESS: `mem_req` and `stall` go low within the same cycle, state returns to IDLE, and the next load completes normally.
